gpio_cmd_master: RTL and testbench
==================================

# gpio_cmd_master

Hardware command initiator for the DSP GPIO control protocol. It drives the 32-bit command word the register file consumes and reads back the register file's 32-bit response word. Configuration writes (reset/enable/phase) and the full BER count readout (latch plus eight 32-bit reads, reassembled into four 64-bit counters) run without MicroBlaze involvement. It sits between local control logic (or a test harness) and the register file's GPIO ports.

## Interface
- GPIO_LEN, 32, command/response word width
- OPCODE_LEN, 8, opcode field width; the field occupies cmd[31:24]
- RSP_WAIT, 1, cycles to wait after a read-issue cycle before sampling the response; legal range 1..15
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cfg_req  in  1  request a register write; level, sampled only in IDLE
- cfg_sel  in  2  register code: 0 reset, 1 enable, 2 phase; 3 is sent unchanged and ignored downstream
- cfg_data  in  23  payload for the data field cmd[22:0]
- cfg_ack  out  1  one-cycle pulse when the cfg request is accepted
- cfg_done  out  1  one-cycle pulse when the cfg write has completed
- rd_req  in  1  request a count readout; level, sampled only in IDLE
- rd_ack  out  1  one-cycle pulse when the rd request is accepted
- rd_done  out  1  one-cycle pulse; the count outputs are updated and valid in this cycle
- busy  out  1  high in every non-IDLE state
- bit_count_r, bit_count_i, error_count_r, error_count_i  out  64 each  last completed readout
- gpio_cmd  out  32  command word {opcode[7:0], enable, data[22:0]}; registered
- gpio_rsp  in  32  response word from the register file

## Operation
- States: IDLE, CFG, CFG_GAP, LATCH, LATCH_GAP, RD_ISSUE, RD_WAIT, DONE.
- IDLE: gpio_cmd = 0. If cfg_req is high, pulse cfg_ack and go to CFG. Otherwise, if rd_req is high, pulse rd_ack and go to LATCH. cfg wins when both requests are high; a rd_req that is still held is accepted on a later IDLE cycle.
- CFG: gpio_cmd = {6'b000000, cfg_sel, 1'b1, cfg_data}, with the cfg_* values captured at accept. Next state is CFG_GAP.
- CFG_GAP: gpio_cmd = 0 and cfg_done = 1. Next state is IDLE.
- LATCH: gpio_cmd = 0x88800000 (op type 2'b10, code 0x08, enable set). Next state is LATCH_GAP.
- LATCH_GAP: gpio_cmd = 0. Set k = 0 and go to RD_ISSUE.
- RD_ISSUE: gpio_cmd = {2'b10, k[5:0], 1'b1, 23'd0}, i.e. 0x80800000 + (k<<24). Next state is RD_WAIT with the wait counter at 0.
- RD_WAIT: gpio_cmd = 0. After RSP_WAIT cycles in this state, capture gpio_rsp into shadow word k on the clock edge that ends the last wait cycle. If k < 7, increment k and go to RD_ISSUE. Otherwise go to DONE.
- Word order for k = 0..7: bit_r[63:32], bit_r[31:0], bit_i[63:32], bit_i[31:0], err_r[63:32], err_r[31:0], err_i[63:32], err_i[31:0].
- All four 64-bit outputs load from the shadow words on the same edge (the one leaving the last RD_WAIT). They never show a partially updated readout.
- DONE: rd_done = 1, gpio_cmd = 0. Next state is IDLE.
- The enable bit is high for exactly one cycle per command, with at least one enable-low cycle between commands. As a result, the downstream latch and reads each execute exactly once.
- Requests arriving while busy are ignored (no ack). Requests are not queued.

## Timing
- Reset (synchronous, rst high at a clock edge) puts the block in IDLE and clears gpio_cmd, busy, all ack/done pulses, the shadow words and all four count outputs to 0. Reset mid-sequence aborts the sequence with no done pulse.
- Cycle numbering: the accept cycle is cycle 0, where the IDLE state sees the request and the ack pulses.
- cfg sequence: the command with enable set is on gpio_cmd in cycle 1. cfg_done and enable low are in cycle 2. busy is high in cycles 1–2. The earliest next accept is cycle 3.
- rd sequence: latch in cycle 1 and gap in cycle 2. Read k issues in cycle 3 + k·(1+RSP_WAIT). rd_done occurs in cycle 3 + 8·(1+RSP_WAIT); with RSP_WAIT=1 this is cycle 19. busy is high from cycle 1 through the rd_done cycle inclusive.
- Response alignment: the register file registers its output one edge after it sees the enable, so RSP_WAIT=1 samples the correct word. Larger values add margin only.

## Test plan
- Reset: hold rst for 3 cycles -> gpio_cmd=0, busy=0, all counts 0, no pulses. Assert rd_req mid-read, then rst -> return to IDLE, no rd_done, counts stay 0.
- cfg write: cfg_sel=1, cfg_data=5 -> cfg_ack in cycle 0; gpio_cmd=0x01800005 for exactly cycle 1; cfg_done and gpio_cmd=0 in cycle 2. A register-file model shows enable_reg=3'b101.
- Readout, RSP_WAIT=1: model counters bit_r=0x0000000100000002, bit_i=0x3, err_r=0xFFFFFFFF00000000, err_i=0x7 -> gpio_cmd=0x88800000 in cycle 1; issue words 0x80800000..0x87800000 in cycles 3,5,…,17; rd_done in cycle 19 with all four outputs equal to the model values.
- Simultaneous request: cfg_req and rd_req both high in IDLE -> cfg_ack only; rd_req held -> rd_ack in cycle 3.
- Busy drop: pulse cfg_req during a readout -> no cfg_ack and no extra enable pulse. Also check the enable-low gap between every pair of enable-high cycles.
- RSP_WAIT=3: with the response delayed by an extra register stage in the model, rd_done occurs in cycle 35 and all counts are correct.

Source files
------------

// File: rtl/gpio_cmd_if.sv
// gpio_cmd_if: bundle between local control, the command master and the register-file GPIO ports
// cfg_req/cfg_sel/cfg_data -> cfg_ack/cfg_done : register write request and its handshake pulses
// rd_req -> rd_ack/rd_done                      : BER count readout request and its handshake pulses
// busy                                          : master is in a command sequence
// bit_count_*/error_count_*                     : last completed 64-bit count readout
// gpio_cmd / gpio_rsp                           : command word to, response word from, the register file
interface gpio_cmd_if #(parameter int GPIO_LEN = 32);
    logic                  cfg_req;
    logic [1:0]            cfg_sel;
    logic [22:0]           cfg_data;
    logic                  cfg_ack;
    logic                  cfg_done;
    logic                  rd_req;
    logic                  rd_ack;
    logic                  rd_done;
    logic                  busy;
    logic [2*GPIO_LEN-1:0] bit_count_r;
    logic [2*GPIO_LEN-1:0] bit_count_i;
    logic [2*GPIO_LEN-1:0] error_count_r;
    logic [2*GPIO_LEN-1:0] error_count_i;
    logic [GPIO_LEN-1:0]   gpio_cmd;
    logic [GPIO_LEN-1:0]   gpio_rsp;
    modport master (
        input  cfg_req, cfg_sel, cfg_data, rd_req, gpio_rsp,
        output cfg_ack, cfg_done, rd_ack, rd_done, busy,
               bit_count_r, bit_count_i, error_count_r, error_count_i, gpio_cmd
    );
    modport slave (
        output cfg_req, cfg_sel, cfg_data, rd_req, gpio_rsp,
        input  cfg_ack, cfg_done, rd_ack, rd_done, busy,
               bit_count_r, bit_count_i, error_count_r, error_count_i, gpio_cmd
    );
endinterface

// File: rtl/gpio_cmd_master.sv
// gpio_cmd_master: issues DSP GPIO config writes and the latch + eight-read BER count readout
// clk, rst : clock and synchronous active-high reset
// bus      : gpio_cmd_if master side (requests/acks, count outputs, gpio_cmd/gpio_rsp)
module gpio_cmd_master #(
    parameter int GPIO_LEN   = 32,
    parameter int OPCODE_LEN = 8,
    parameter int RSP_WAIT   = 1
) (
    input logic        clk,
    input logic        rst,
    gpio_cmd_if.master bus
);
    localparam int DATA_LEN = GPIO_LEN - OPCODE_LEN - 1;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CFG       = 3'd1;
    localparam logic [2:0] CFG_GAP   = 3'd2;
    localparam logic [2:0] LATCH     = 3'd3;
    localparam logic [2:0] LATCH_GAP = 3'd4;
    localparam logic [2:0] RD_ISSUE  = 3'd5;
    localparam logic [2:0] RD_WAIT   = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;
    localparam logic [3:0] WAIT_LAST = 4'(RSP_WAIT - 1);

    logic [2:0]            state, state_nxt;
    logic [2:0]            k;
    logic [3:0]            wcnt;
    logic                  last_wait;
    logic [GPIO_LEN-1:0]   cmd_q, cmd_nxt;
    logic [GPIO_LEN-1:0]   shadow [8];
    logic [2*GPIO_LEN-1:0] bit_r, bit_i, err_r, err_i;

    function automatic logic [GPIO_LEN-1:0] word(input logic [OPCODE_LEN-1:0] op,
                                                 input logic [DATA_LEN-1:0] data);
        return {op, 1'b1, data};
    endfunction

    function automatic logic [OPCODE_LEN-1:0] rd_op(input logic [2:0] kk);
        return OPCODE_LEN'({2'b10, 3'b000, kk});
    endfunction

    assign last_wait         = state == RD_WAIT && wcnt == WAIT_LAST;
    assign bus.cfg_ack       = state == IDLE && bus.cfg_req;
    assign bus.rd_ack        = state == IDLE && !bus.cfg_req && bus.rd_req;
    assign bus.cfg_done      = state == CFG_GAP;
    assign bus.rd_done       = state == DONE;
    assign bus.busy          = state != IDLE;
    assign bus.gpio_cmd      = cmd_q;
    assign bus.bit_count_r   = bit_r;
    assign bus.bit_count_i   = bit_i;
    assign bus.error_count_r = err_r;
    assign bus.error_count_i = err_i;

    // gpio_cmd is registered, so the word for the next state is formed here and
    // loaded on the same edge as the state; every command is followed by a zero word.
    always_comb begin
        state_nxt = state;
        cmd_nxt   = '0;
        case (state)
            IDLE: begin
                if (bus.cfg_req) begin
                    state_nxt = CFG;
                    cmd_nxt   = word(OPCODE_LEN'(bus.cfg_sel), DATA_LEN'(bus.cfg_data));
                end else if (bus.rd_req) begin
                    state_nxt = LATCH;
                    cmd_nxt   = word(OPCODE_LEN'(8'h88), '0);
                end
            end
            CFG:       state_nxt = CFG_GAP;
            CFG_GAP:   state_nxt = IDLE;
            LATCH:     state_nxt = LATCH_GAP;
            LATCH_GAP: begin
                state_nxt = RD_ISSUE;
                cmd_nxt   = word(rd_op(3'd0), '0);
            end
            RD_ISSUE:  state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (last_wait) begin
                    state_nxt = (k == 3'd7) ? DONE : RD_ISSUE;
                    cmd_nxt   = (k == 3'd7) ? '0 : word(rd_op(k + 3'd1), '0);
                end
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cmd_q  <= '0;
            k      <= '0;
            wcnt   <= '0;
            shadow <= '{default: '0};
            bit_r  <= '0;
            bit_i  <= '0;
            err_r  <= '0;
            err_i  <= '0;
        end else begin
            state <= state_nxt;
            cmd_q <= cmd_nxt;
            wcnt  <= (state == RD_WAIT) ? wcnt + 4'd1 : '0;
            if (state == LATCH_GAP)
                k <= '0;
            else if (last_wait)
                k <= k + 3'd1;
            if (last_wait)
                shadow[k] <= bus.gpio_rsp;
            // The last word comes straight from gpio_rsp so all four counters update together.
            if (last_wait && k == 3'd7) begin
                bit_r <= {shadow[0], shadow[1]};
                bit_i <= {shadow[2], shadow[3]};
                err_r <= {shadow[4], shadow[5]};
                err_i <= {shadow[6], bus.gpio_rsp};
            end
        end
    end
endmodule

// File: tb/tb_gpio_cmd_master.sv
// tb_gpio_cmd_master: scoreboard bench driving RSP_WAIT=1 and RSP_WAIT=3 masters with shared stimulus
module tb_gpio_cmd_master;
    typedef struct { logic [31:0] cmd; int cyc; } cmd_ev_t;
    typedef struct { int acc; logic [1:0] sel; logic [22:0] data; } cfg_ev_t;
    typedef struct { int acc; logic [63:0] br, bi, er, ei; } rd_ev_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        cfg_req = 0, rd_req = 0;
    logic [1:0]  cfg_sel = 0;
    logic [22:0] cfg_data = 0;
    logic [63:0] m_br = 0, m_bi = 0, m_er = 0, m_ei = 0;
    int          cyc = 0;
    int          vecs = 0, errs = 0;
    cmd_ev_t     exp_cmd [2][$];
    cfg_ev_t     exp_cfg [2][$];
    rd_ev_t      exp_rd  [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int W = g ? 3 : 1;
        gpio_cmd_if  bus();
        logic [63:0] snap [4];
        logic [22:0] regs [4];
        logic [31:0] rsp_a = 0, rsp_b = 0;

        gpio_cmd_master #(.RSP_WAIT(W)) dut (.clk(clk), .rst(rst), .bus(bus));

        assign bus.cfg_req  = cfg_req;
        assign bus.cfg_sel  = cfg_sel;
        assign bus.cfg_data = cfg_data;
        assign bus.rd_req   = rd_req;
        assign bus.gpio_rsp = (W == 3) ? rsp_b : rsp_a;

        // Register file: acts on each enabled command; read data appears one edge later,
        // with one more register stage for the RSP_WAIT=3 master.
        always @(posedge clk) begin
            rsp_b <= rsp_a;
            if (bus.gpio_cmd[23]) begin
                if (bus.gpio_cmd[31:24] == 8'h88)
                    snap <= '{m_br, m_bi, m_er, m_ei};
                else if (bus.gpio_cmd[31:27] == 5'b10000)
                    rsp_a <= bus.gpio_cmd[24] ? snap[bus.gpio_cmd[26:25]][31:0]
                                              : snap[bus.gpio_cmd[26:25]][63:32];
                else if (bus.gpio_cmd[31:26] == 6'd0)
                    regs[bus.gpio_cmd[25:24]] <= bus.gpio_cmd[22:0];
            end
        end

        initial begin
            logic    prev_en;
            cmd_ev_t ce;
            cfg_ev_t fe;
            rd_ev_t  re;
            prev_en = 0;
            forever begin
                @(negedge clk);
                if (rst) prev_en = 0;
                else begin
                    if (bus.gpio_cmd[23]) begin
                        chk("en_gap", 64'(prev_en), '0);
                        if (exp_cmd[g].size() == 0) chk("extra_en", 64'(bus.gpio_cmd), '0);
                        else begin
                            ce = exp_cmd[g].pop_front();
                            chk("cmd_word", 64'(bus.gpio_cmd), 64'(ce.cmd));
                            chk("cmd_cycle", 64'(cyc), 64'(ce.cyc));
                        end
                    end
                    prev_en = bus.gpio_cmd[23];
                    if (bus.cfg_ack)
                        chk("cfg_ack_cycle", 64'(cyc), 64'(exp_cfg[g].size() != 0 ? exp_cfg[g][0].acc : -1));
                    if (bus.rd_ack)
                        chk("rd_ack_cycle", 64'(cyc), 64'(exp_rd[g].size() != 0 ? exp_rd[g][0].acc : -1));
                    if (bus.cfg_done) begin
                        if (exp_cfg[g].size() == 0) chk("cfg_done_spurious", 64'(bus.cfg_done), '0);
                        else begin
                            fe = exp_cfg[g].pop_front();
                            chk("cfg_done_cycle", 64'(cyc), 64'(fe.acc + 2));
                            chk("cfg_done_cmd", 64'(bus.gpio_cmd), '0);
                            chk("cfg_reg", 64'(regs[fe.sel]), 64'(fe.data));
                        end
                    end
                    if (bus.rd_done) begin
                        if (exp_rd[g].size() == 0) chk("rd_done_spurious", 64'(bus.rd_done), '0);
                        else begin
                            re = exp_rd[g].pop_front();
                            chk("rd_done_cycle", 64'(cyc), 64'(re.acc + 3 + 8 * (1 + W)));
                            chk("bit_count_r", bus.bit_count_r, re.br);
                            chk("bit_count_i", bus.bit_count_i, re.bi);
                            chk("error_count_r", bus.error_count_r, re.er);
                            chk("error_count_i", bus.error_count_i, re.ei);
                            chk("rd_done_busy", 64'(bus.busy), 64'(1));
                        end
                    end
                end
            end
        end
    end

    task automatic push_cfg(input logic [1:0] sel, input logic [22:0] data, input int acc);
        for (int i = 0; i < 2; i++) begin
            exp_cmd[i].push_back('{{6'd0, sel, 1'b1, data}, acc + 1});
            exp_cfg[i].push_back('{acc, sel, data});
        end
    endtask

    task automatic push_rd(input int acc);
        for (int i = 0; i < 2; i++) begin
            int w = i ? 3 : 1;
            exp_cmd[i].push_back('{32'h88800000, acc + 1});
            for (int j = 0; j < 8; j++)
                exp_cmd[i].push_back('{32'h80800000 + (32'(j) << 24), acc + 3 + j * (1 + w)});
            exp_rd[i].push_back('{acc, m_br, m_bi, m_er, m_ei});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((u[0].bus.busy || u[1].bus.busy) && n < 100) begin
            step();
            n++;
        end
        if (n == 100) chk("idle_timeout", 64'({u[0].bus.busy, u[1].bus.busy}), '0);
    endtask

    task automatic chk_reset();
        chk("rst_cmd", {u[0].bus.gpio_cmd, u[1].bus.gpio_cmd}, '0);
        chk("rst_flags", 64'({u[0].bus.busy, u[0].bus.cfg_ack, u[0].bus.cfg_done, u[0].bus.rd_ack,
                              u[0].bus.rd_done, u[1].bus.busy, u[1].bus.cfg_ack, u[1].bus.cfg_done,
                              u[1].bus.rd_ack, u[1].bus.rd_done}), '0);
        chk("rst_cnt0", u[0].bus.bit_count_r | u[0].bus.bit_count_i |
                        u[0].bus.error_count_r | u[0].bus.error_count_i, '0);
        chk("rst_cnt1", u[1].bus.bit_count_r | u[1].bus.bit_count_i |
                        u[1].bus.error_count_r | u[1].bus.error_count_i, '0);
    endtask

    task automatic do_cfg(input logic [1:0] sel, input logic [22:0] data);
        cfg_req  = 1;
        cfg_sel  = sel;
        cfg_data = data;
        push_cfg(sel, data, cyc);
        step();
        cfg_req  = 0;
        cfg_sel  = 2'($urandom);
        cfg_data = 23'($urandom);
        wait_idle();
    endtask

    task automatic do_rd();
        rd_req = 1;
        push_rd(cyc);
        step();
        rd_req = 0;
        wait_idle();
    endtask

    task automatic rand_counts();
        m_br = {$urandom, $urandom};
        m_bi = {$urandom, $urandom};
        m_er = {$urandom, $urandom};
        m_ei = {$urandom, $urandom};
    endtask

    initial begin
        int acc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        step();
        rst = 0;

        // Reset in the middle of a readout: no done pulse, counts stay 0.
        rand_counts();
        rd_req = 1;
        push_rd(cyc);
        step();
        rd_req = 0;
        repeat (6) step();
        rst = 1;
        step();
        for (int i = 0; i < 2; i++) begin
            exp_cmd[i].delete();
            exp_cfg[i].delete();
            exp_rd[i].delete();
        end
        step();
        rst = 0;
        @(negedge clk);
        chk_reset();
        repeat (40) step();
        chk_reset();

        m_br = 64'h0000000100000002;
        m_bi = 64'h3;
        m_er = 64'hFFFFFFFF00000000;
        m_ei = 64'h7;
        do_rd();
        do_cfg(2'd1, 23'd5);

        // cfg and rd requested together: cfg first, held rd accepted three cycles later.
        acc = cyc;
        cfg_req  = 1;
        rd_req   = 1;
        cfg_sel  = 2'd2;
        cfg_data = 23'h2AAAAA;
        push_cfg(2'd2, 23'h2AAAAA, acc);
        rand_counts();
        push_rd(acc + 3);
        step();
        cfg_req = 0;
        repeat (2) step();
        step();
        rd_req = 0;
        wait_idle();

        // cfg pulse while a readout is running is dropped.
        rand_counts();
        rd_req = 1;
        push_rd(cyc);
        step();
        rd_req = 0;
        repeat (4) step();
        cfg_req  = 1;
        cfg_sel  = 2'd0;
        cfg_data = 23'h123;
        step();
        cfg_req = 0;
        wait_idle();

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(1) == 1) do_cfg(2'($urandom), 23'($urandom));
            else begin
                rand_counts();
                do_rd();
            end
            repeat ($urandom_range(2)) step();
        end

        repeat (5) step();
        chk("leftover", 64'(exp_cmd[0].size() + exp_cmd[1].size() + exp_cfg[0].size() +
                            exp_cfg[1].size() + exp_rd[0].size() + exp_rd[1].size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
